// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-port (C = CPU/bus, D = DMA) arbiter and sequencer in front of the
//   sdram_top request/ack controller. One transaction is latched at a time,
//   the controller request level is held until acknowledged, the master ack
//   is delayed by ACK_DLY cycles from the controller ack, and the DQM byte
//   masks are produced synchronously from the latched byte select.
//
// Ports
//   clk_p, rst_n                 clock, async active-low reset
//   c_* / d_*                    master ports: stb, we, sel, adr, wdat in;
//                                rdat, ack out
//   s_wr_req, s_rd_req           controller request levels
//   s_wr_ack, s_rd_ack, s_rdat   controller acknowledges and read data
//   s_addr, s_be, s_wdat         latched transaction for the controller
//   s_init_done                  controller initialisation complete
//   dqm_h, dqm_l                 SDRAM byte masks
//   grant                        one-hot owner {D,C}, 00 when idle
//   tmo_err                      one-cycle pulse when a request times out
//
// State  | meaning
// IDLE   | no owner; arbitrate when controller ready and a port strobes
// REQ    | request level held to controller, timeout counter running
// DLY    | controller acked; delaying toward master ack, read capture at end
// DONE   | owner ack asserted while owner strobes; release on stb low
module sdram_arbiter #(
  parameter int AW      = 21,
  parameter int ACK_DLY = 2,
  parameter int TMO     = 255
) (
  input  logic          clk_p,
  input  logic          rst_n,
  input  logic          c_stb,
  input  logic          c_we,
  input  logic [1:0]    c_sel,
  input  logic [AW-1:0] c_adr,
  input  logic [15:0]   c_wdat,
  output logic [15:0]   c_rdat,
  output logic          c_ack,
  input  logic          d_stb,
  input  logic          d_we,
  input  logic [1:0]    d_sel,
  input  logic [AW-1:0] d_adr,
  input  logic [15:0]   d_wdat,
  output logic [15:0]   d_rdat,
  output logic          d_ack,
  output logic          s_wr_req,
  output logic          s_rd_req,
  input  logic          s_wr_ack,
  input  logic          s_rd_ack,
  output logic [AW:0]   s_addr,
  output logic [1:0]    s_be,
  output logic [15:0]   s_wdat,
  input  logic [15:0]   s_rdat,
  input  logic          s_init_done,
  output logic          dqm_h,
  output logic          dqm_l,
  output logic [1:0]    grant,
  output logic          tmo_err
);

  typedef enum logic [1:0] {IDLE, REQ, DLY, DONE} state_t;

  // Timeout counter counts down from TMO-1 so the request is held for TMO cycles.
  localparam logic [7:0] TMO_LD = 8'(TMO - 1);
  // ACK_DLY-1 cycles in DLY; with ACK_DLY=1 REQ goes straight to DONE.
  localparam int         DLY_N  = (ACK_DLY >= 2) ? (ACK_DLY - 2) : 0;
  localparam logic [1:0] DLY_LD = 2'(DLY_N);

  state_t      state_q, state_d;
  logic        owner_q;     // 0 = C, 1 = D
  logic        we_q;
  logic        rr_last_q;   // last owner, 1 = D
  logic [7:0]  tmo_cnt_q;
  logic [1:0]  dly_cnt_q;

  logic win_d, own_stb, ack_match;
  logic do_grant, do_cap, do_tmo, do_rel;

  assign win_d     = d_stb & (~c_stb | ~rr_last_q);
  assign own_stb   = owner_q ? d_stb : c_stb;
  assign ack_match = we_q ? s_wr_ack : s_rd_ack;

  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_cap   = 1'b0;
    do_tmo   = 1'b0;
    do_rel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_init_done && (c_stb || d_stb)) begin
          do_grant = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ack_match) begin
          if (ACK_DLY <= 1) begin
            do_cap  = ~we_q;
            state_d = DONE;
          end else begin
            state_d = DLY;
          end
        end else if (tmo_cnt_q == 8'd0) begin
          do_tmo  = 1'b1;
          state_d = DONE;
        end
      end
      DLY: begin
        if (dly_cnt_q == 2'd0) begin
          do_cap  = ~we_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!own_stb) begin
          do_rel  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      rr_last_q <= 1'b1;
      tmo_cnt_q <= 8'd0;
      dly_cnt_q <= 2'd0;
      s_addr    <= '0;
      s_be      <= 2'b00;
      s_wdat    <= 16'h0000;
      dqm_h     <= 1'b0;
      dqm_l     <= 1'b0;
      grant     <= 2'b00;
      tmo_err   <= 1'b0;
      c_rdat    <= 16'h0000;
      d_rdat    <= 16'h0000;
    end else begin
      state_q <= state_d;
      tmo_err <= do_tmo;
      if (do_grant) begin
        owner_q   <= win_d;
        we_q      <= win_d ? d_we : c_we;
        s_addr    <= {1'b0, (win_d ? d_adr : c_adr)};
        s_be      <= win_d ? d_sel : c_sel;
        s_wdat    <= win_d ? d_wdat : c_wdat;
        // Reads never mask bytes; writes mask the unselected lanes.
        dqm_h     <= (win_d ? d_we : c_we) & ~(win_d ? d_sel[1] : c_sel[1]);
        dqm_l     <= (win_d ? d_we : c_we) & ~(win_d ? d_sel[0] : c_sel[0]);
        grant     <= win_d ? 2'b10 : 2'b01;
        tmo_cnt_q <= TMO_LD;
      end
      if (state_q == REQ) begin
        if (ack_match) begin
          dly_cnt_q <= DLY_LD;
        end else if (tmo_cnt_q != 8'd0) begin
          tmo_cnt_q <= tmo_cnt_q - 8'd1;
        end
      end
      if (state_q == DLY && dly_cnt_q != 2'd0) begin
        dly_cnt_q <= dly_cnt_q - 2'd1;
      end
      if (do_cap) begin
        if (owner_q) d_rdat <= s_rdat;
        else         c_rdat <= s_rdat;
      end
      if (do_rel) begin
        rr_last_q <= owner_q;
        grant     <= 2'b00;
      end
    end
  end

  assign s_wr_req = (state_q == REQ) &  we_q;
  assign s_rd_req = (state_q == REQ) & ~we_q;
  assign c_ack    = (state_q == DONE) & ~owner_q & c_stb;
  assign d_ack    = (state_q == DONE) &  owner_q & d_stb;

endmodule
